// File: rtl/bus_arbiter.sv
// Memory bus arbiter between the 65C02 core and a single DMA requester.
// Stalls the core through RDY during DMA tenure and replays its in-flight read byte on return.
module bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int MIN_CPU   = 2,
  parameter int SYNC_ONLY = 0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  input  logic        cpu_sync,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  input  logic        ext_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_ad,
  input  logic [7:0]  dma_do,
  input  logic        dma_we,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_ad,
  output logic [7:0]  mem_do,
  output logic        mem_we,
  input  logic [7:0]  mem_di
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(MIN_CPU + 1);

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DMA = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [BW-1:0] r_burstCnt;
  logic [CW-1:0] r_coolCnt;
  logic          r_replay;
  logic          r_capPend;
  logic [7:0]    r_cap;
  logic          r_dmaRvalid;

  logic w_isDma;
  logic w_ack;
  logic w_handover;
  logic w_return;
  logic w_capBlock;

  assign w_isDma    = (r_state == ST_DMA);
  assign w_ack      = w_isDma & dma_req & ext_rdy;
  assign w_capBlock = r_capPend & ~ext_rdy;

  assign mem_ad     = w_isDma ? dma_ad : cpu_ad;
  assign mem_do     = w_isDma ? dma_do : cpu_do;
  assign mem_we     = w_isDma ? dma_we : cpu_we;
  assign cpu_rdy    = w_isDma ? 1'b0 : ext_rdy;
  assign cpu_di     = r_replay ? r_cap : mem_di;
  assign dma_gnt    = w_isDma;
  assign dma_ack    = w_ack;
  assign dma_rvalid = r_dmaRvalid;
  assign dma_rdata  = mem_di;

  // Return waits until the core's in-flight byte is safely captured.
  always_comb begin
    w_nextState = r_state;
    w_handover  = 1'b0;
    w_return    = 1'b0;
    case (r_state)
      ST_CPU: begin
        if (dma_req && ext_rdy && (r_coolCnt == '0) &&
            ((SYNC_ONLY == 0) || cpu_sync)) begin
          w_handover  = 1'b1;
          w_nextState = ST_DMA;
        end
      end
      ST_DMA: begin
        if (!w_capBlock &&
            (!dma_req || (w_ack && (r_burstCnt == BW'(MAX_BURST - 1))))) begin
          w_return    = 1'b1;
          w_nextState = ST_CPU;
        end
      end
      default: w_nextState = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state     <= ST_CPU;
      r_burstCnt  <= '0;
      r_coolCnt   <= '0;
      r_replay    <= 1'b0;
      r_capPend   <= 1'b0;
      r_cap       <= '0;
      r_dmaRvalid <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_dmaRvalid <= w_ack & ~dma_we;
      if (r_state == ST_CPU) begin
        if (ext_rdy) begin
          r_replay <= 1'b0;
          if (r_coolCnt != '0) begin
            r_coolCnt <= r_coolCnt - 1'b1;
          end
        end
        if (w_handover) begin
          r_capPend  <= 1'b1;
          r_burstCnt <= '0;
        end
      end else begin
        // The first ready DMA cycle still carries the core's read data.
        if (r_capPend && ext_rdy) begin
          r_cap     <= mem_di;
          r_capPend <= 1'b0;
        end
        if (w_ack) begin
          r_burstCnt <= r_burstCnt + 1'b1;
        end
        if (w_return) begin
          r_replay  <= 1'b1;
          r_coolCnt <= CW'(MIN_CPU - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scripted cycles, DMA read data and replay bytes via queues.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_sync;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        ext_rdy;
  logic        dma_req;
  logic [15:0] dma_ad;
  logic [7:0]  dma_do;
  logic        dma_we;
  logic        dma_gnt;
  logic        dma_ack;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_ad;
  logic [7:0]  mem_do;
  logic        mem_we;
  logic [7:0]  mem_di;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } rdItem_t;

  rdItem_t    rdQ[$];
  logic [7:0] replayQ[$];

  bus_arbiter #(.MAX_BURST(8), .MIN_CPU(2), .SYNC_ONLY(0)) dut (
    .clk(clk), .RST(RST),
    .cpu_ad(cpu_ad), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_sync(cpu_sync),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .ext_rdy(ext_rdy),
    .dma_req(dma_req), .dma_ad(dma_ad), .dma_do(dma_do), .dma_we(dma_we),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_ad(mem_ad), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memFn(input logic [15:0] a);
    if (a == 16'h0200) return 8'hA5;
    if (a == 16'h3000) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'h69;
  endfunction

  // Memory answers one cycle after its address; a held cycle keeps the old data.
  always @(posedge clk) begin
    if (ext_rdy) mem_di <= memFn(mem_ad);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle, checks it mid-cycle, then advances to the next negedge.
  task automatic applyStimulus(input logic rstIn, input logic req, input logic ext,
                               input logic [15:0] cAd, input logic [15:0] dAd, input logic dWe,
                               input logic expGnt, input logic expAck,
                               input logic chkDi, input logic [7:0] expDi);
    rdItem_t item;
    logic    expValid;
    RST     = rstIn;
    dma_req = req;
    ext_rdy = ext;
    cpu_ad  = cAd;
    dma_ad  = dAd;
    dma_we  = dWe;
    #1;
    checkOutput("dma_gnt", dma_gnt, expGnt);
    checkOutput("dma_ack", dma_ack, expAck);
    checkOutput("cpu_rdy", cpu_rdy, expGnt ? 1'b0 : ext);
    checkOutput("mem_ad", mem_ad, expGnt ? dAd : cAd);
    checkOutput("mem_we", mem_we, expGnt ? dWe : cpu_we);
    checkOutput("mem_do", mem_do, expGnt ? dma_do : cpu_do);
    if (chkDi) checkOutput("cpu_di", cpu_di, expDi);
    item = (rdQ.size() > 0) ? rdQ.pop_front() : '0;
    expValid = rstIn ? 1'b0 : item.valid;
    checkOutput("dma_rvalid", dma_rvalid, expValid);
    if (expValid) checkOutput("dma_rdata", dma_rdata, item.data);
    rdQ.push_back('{valid: expAck & ~dWe, data: memFn(dAd)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [15:0] cAd);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, cAd, 16'h0000, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    cpu_do   = 8'h11;
    dma_do   = 8'h22;
    cpu_we   = 1'b0;
    cpu_sync = 1'b0;
    rdQ.push_back('0);

    $display("[TB] reset behaviour");
    applyStimulus(1, 1, 1, 16'h1234, 16'h5555, 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 1, 16'h1234, 16'h5555, 0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 16'h1234, 16'h5555, 0, 0, 0, 0, 8'h00);

    $display("[TB] no DMA pass-through");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 16'h1234, 16'h5555, 0, 0, 0, 1, memFn(16'h1234));

    $display("[TB] single short burst with replay");
    applyStimulus(0, 1, 1, 16'h0200, 16'h3000, 0, 0, 0, 0, 8'h00);
    replayQ.push_back(memFn(16'h0200));
    applyStimulus(0, 1, 1, 16'h0201, 16'h3000, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 16'h0201, 16'h3001, 1, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 16'h0201, 16'h3000, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0201, 16'h3000, 0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0201, 16'h3000, 0, 0, 0, 1, replayQ.pop_front());
    applyStimulus(0, 0, 1, 16'h0201, 16'h3000, 0, 0, 0, 1, memFn(16'h0201));
    idle(2, 16'h0400);

    $display("[TB] long request, bounded bursts and cooldown");
    for (int k = 0; k <= 20; k++) begin
      logic expG;
      expG = !((k % 10) == 0 || (k % 10) == 9);
      if (k == 0 || k == 10) replayQ.push_back(memFn(16'h0400));
      if (k == 9 || k == 19)
        applyStimulus(0, k < 20, 1, 16'h0400, 16'h3000 + 16'(k), 0, expG, expG, 1, replayQ.pop_front());
      else
        applyStimulus(0, k < 20, 1, 16'h0400, 16'h3000 + 16'(k), 0, expG, expG, 0, 8'h00);
    end
    idle(2, 16'h0400);

    $display("[TB] ext_rdy hold in first DMA cycle and on replay");
    applyStimulus(0, 1, 1, 16'h0200, 16'h3010, 0, 0, 0, 0, 8'h00);
    replayQ.push_back(memFn(16'h0200));
    applyStimulus(0, 1, 0, 16'h0201, 16'h3010, 0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 16'h0201, 16'h3010, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 16'h0201, 16'h3011, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0201, 16'h3011, 0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 16'h0201, 16'h3011, 0, 0, 0, 1, replayQ[0]);
    applyStimulus(0, 0, 1, 16'h0201, 16'h3011, 0, 0, 0, 1, replayQ.pop_front());
    applyStimulus(0, 0, 1, 16'h0201, 16'h3011, 0, 0, 0, 1, memFn(16'h0201));
    idle(2, 16'h0400);

    $display("[TB] reset mid-burst");
    applyStimulus(0, 1, 1, 16'h0200, 16'h3020, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 16'h0201, 16'h3020, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 16'h0201, 16'h3021, 0, 1, 1, 0, 8'h00);
    applyStimulus(1, 1, 1, 16'h0300, 16'h3022, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0300, 16'h3022, 0, 0, 0, 1, memFn(16'h0300));
    applyStimulus(0, 1, 1, 16'h0300, 16'h3023, 0, 0, 0, 0, 8'h00);
    replayQ.push_back(memFn(16'h0300));
    applyStimulus(0, 1, 1, 16'h0301, 16'h3023, 0, 1, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0301, 16'h3024, 0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0301, 16'h3024, 0, 0, 0, 1, replayQ.pop_front());
    idle(2, 16'h0400);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
